// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the Saratoga pipeline hazard/flush controller.
// Holds the register-address type, forwarding selects and the trap FSM states.
// Pure declarations plus one small helper; no logic of its own.
package hazard_ctrl_pkg;

    localparam int GPR_AW = 5;
    typedef logic [GPR_AW-1:0] gpr_addr_t;

    // Forwarding mux select for one EX operand.
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    // Trap entry sequencing.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        TRAP  = 2'd2
    } hazard_state_t;

    // Producer stage indices used for the per-pair match grid.
    localparam int NUM_SRC = 2;
    localparam int NUM_STG = 3;
    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    // The youngest producer wins: MEM holds newer data than WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_raw.sv
// raw_match: flags one ID source register against one producer stage destination.
// Latency: purely combinational.
// x0 never matches; a bubble in the producer stage never matches.
module raw_match
    import hazard_ctrl_pkg::*;
(
    input  logic      src_used,
    input  gpr_addr_t src,
    input  logic      stage_bubble,
    input  gpr_addr_t stage_dest,
    output logic      hit
);

    assign hit = src_used & (src != '0) & ~stage_bubble & (src == stage_dest);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/squash/forward control for the 5-stage Saratoga pipeline.
// Stall, squash and forward selects are combinational; trap_ack and bus_fault are registered.
// Build option HAZARD_FWD_EN: forward from MEM/WB and stall only on load-use hazards.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      id_bubble,
    input  gpr_addr_t id_rs1,
    input  gpr_addr_t id_rs2,
    input  logic      id_rs1_used,
    input  logic      id_rs2_used,
    input  logic      ex_bubble,
    input  logic      mem_bubble,
    input  logic      wb_bubble,
    input  gpr_addr_t ex_dest,
    input  gpr_addr_t mem_dest,
    input  gpr_addr_t wb_dest,
    input  logic      ex_is_load,
    input  logic      ex_redirect,
    input  logic      mem_wait,
    input  logic      trap_req,
    output logic      pc_stall,
    output logic      if_id_stall,
    output logic      if_id_squash,
    output logic      id_ex_stall,
    output logic      id_ex_squash,
    output logic      ex_mem_stall,
    output logic      ex_mem_squash,
    output fwd_sel_t  fwd_rs1_sel,
    output fwd_sel_t  fwd_rs2_sel,
    output logic      trap_ack,
    output logic      bus_fault
);

`ifdef HAZARD_FWD_EN
    localparam bit FWD_ON    = 1'b1;
    localparam bit LOAD_ONLY = 1'b1;
`else
    localparam bit FWD_ON    = 1'b0;
    localparam bit LOAD_ONLY = 1'b0;
`endif

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    hazard_state_t state;
    logic [7:0]    wait_cnt;

    gpr_addr_t src_a  [NUM_SRC];
    logic      used_a [NUM_SRC];
    gpr_addr_t dst_a  [NUM_STG];
    logic      bub_a  [NUM_STG];
    logic [NUM_SRC-1:0][NUM_STG-1:0] hit_raw;
    logic [NUM_SRC-1:0][NUM_STG-1:0] hit;

    assign src_a[0]       = id_rs1;
    assign src_a[1]       = id_rs2;
    assign used_a[0]      = id_rs1_used;
    assign used_a[1]      = id_rs2_used;
    assign dst_a[STG_EX]  = ex_dest;
    assign dst_a[STG_MEM] = mem_dest;
    assign dst_a[STG_WB]  = wb_dest;
    assign bub_a[STG_EX]  = ex_bubble;
    assign bub_a[STG_MEM] = mem_bubble;
    assign bub_a[STG_WB]  = wb_bubble;

    for (genvar r = 0; r < NUM_SRC; r++) begin : g_src
        for (genvar s = 0; s < NUM_STG; s++) begin : g_stg
            raw_match u_match (
                .src_used     (used_a[r]),
                .src          (src_a[r]),
                .stage_bubble (bub_a[s]),
                .stage_dest   (dst_a[s]),
                .hit          (hit_raw[r][s])
            );
        end
    end

    // An empty ID slot cannot consume anything, so it raises no match.
    assign hit = id_bubble ? '0 : hit_raw;

    logic ex_hit, older_hit, data_hazard, drain_done;
    assign ex_hit      = hit[0][STG_EX]  | hit[1][STG_EX];
    assign older_hit   = hit[0][STG_MEM] | hit[1][STG_MEM] | hit[0][STG_WB] | hit[1][STG_WB];
    // With forwarding only a load in EX lacks its data in time; otherwise any RAW stalls.
    assign data_hazard = (ex_hit & (ex_is_load | ~LOAD_ONLY)) | (older_hit & ~LOAD_ONLY);
    assign drain_done  = ~mem_wait & mem_bubble & wb_bubble;

    // Forwarding selects, forced to FWD_NONE in reset or when forwarding is built out.
    always_comb begin
        fwd_rs1_sel = FWD_NONE;
        fwd_rs2_sel = FWD_NONE;
        if (rst_n && FWD_ON) begin
            fwd_rs1_sel = fwd_pick(hit[0][STG_MEM], hit[0][STG_WB]);
            fwd_rs2_sel = fwd_pick(hit[1][STG_MEM], hit[1][STG_WB]);
        end
    end

    // Stage-register stall/squash decode from the FSM state and current pipeline events.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_squash  = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_squash  = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_squash = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (trap_req) begin
                        pc_stall      = 1'b1;
                        if_id_squash  = 1'b1;
                        id_ex_squash  = 1'b1;
                        ex_mem_squash = 1'b1;
                    end else if (mem_wait) begin
                        // Holds a pending redirect in EX until memory answers.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else if (ex_redirect && !ex_bubble) begin
                        if_id_squash = 1'b1;
                        id_ex_squash = 1'b1;
                    end else if (data_hazard) begin
                        // Bubble into EX; squash outranks stall so id_ex_stall stays low.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_squash = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_stall      = 1'b1;
                    if_id_squash  = 1'b1;
                    id_ex_squash  = 1'b1;
                    ex_mem_squash = 1'b1;
                end
                TRAP: begin
                    if_id_squash = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Trap entry FSM; trap_ack is raised on entry to TRAP so it is high exactly that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            trap_ack <= 1'b0;
        end else begin
            trap_ack <= 1'b0;
            case (state)
                RUN:     if (trap_req) state <= DRAIN;
                DRAIN:   if (drain_done) begin
                             state    <= TRAP;
                             trap_ack <= 1'b1;
                         end
                TRAP:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Data-memory wait watchdog: one bus_fault pulse per MEM_TIMEOUT continuous wait cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= 8'd0;
            bus_fault <= 1'b0;
        end else begin
            bus_fault <= 1'b0;
            if (!mem_wait) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt == TO_LAST) begin
                wait_cnt  <= 8'd0;
                bus_fault <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and flush controller for the 5-stage Saratoga core (IF, ID, EX, MEM, WB). It drives the `stall`/`squash` pair of every inter-stage register (IF/ID, ID/EX, EX/MEM) and the PC hold. It resolves load-use and RAW hazards, branch redirects, data-memory wait states and trap drains. A small FSM sequences trap entry, and a counter watches data-memory wait states for timeouts.

## Interface
- `MEM_TIMEOUT`, 255: cycles of continuous `mem_wait` before `bus_fault` pulses; legal range 1..255.
- `clk  in  1  clock`
- `rst_n  in  1  reset, synchronous, active-low`
- `id_bubble  in  1  ID holds no valid instruction`
- `id_rs1, id_rs2  in  rv32::gpr_addr_t  ID source registers`
- `id_rs1_used, id_rs2_used  in  1  source actually read`
- `ex_bubble, mem_bubble, wb_bubble  in  1  stage invalid`
- `ex_dest, mem_dest, wb_dest  in  rv32::gpr_addr_t  stage destination; x0 means none`
- `ex_is_load  in  1  EX instruction is a load`
- `ex_redirect  in  1  EX resolved taken branch/jump`
- `mem_wait  in  1  data memory not ready`
- `trap_req  in  1  MEM/CSR raises exception or interrupt`
- `pc_stall  out  1  hold PC`
- `if_id_stall, if_id_squash  out  1  IF/ID control`
- `id_ex_stall, id_ex_squash  out  1  ID/EX control`
- `ex_mem_stall, ex_mem_squash  out  1  EX/MEM control`
- `fwd_rs1_sel, fwd_rs2_sel  out  fwd_sel_t  forwarding mux selects`
- `trap_ack  out  1  registered, one-cycle; CSR unit loads mtvec and redirects PC`
- `bus_fault  out  1  registered, one-cycle timeout pulse`

## Operation
- FSM states: RUN, DRAIN, TRAP.
- **RUN**, priority highest first:
  - `trap_req` -> squash IF/ID, ID/EX, EX/MEM; assert `pc_stall`; go to DRAIN.
  - `mem_wait` -> stall PC, IF/ID, ID/EX, EX/MEM; no squashes.
  - `ex_redirect & !ex_bubble` -> squash IF/ID and ID/EX.
  - Data hazard -> `pc_stall`, `if_id_stall`, `id_ex_squash`. `id_ex_stall` stays 0, because squash outranks stall in the stage register.
- **DRAIN**: keep `pc_stall` and all three squashes. Leave for TRAP once `!mem_wait & mem_bubble & wb_bubble`.
- **TRAP**: `trap_ack`=1 for one cycle; squash IF/ID; return to RUN.
- A match is `id_rsN_used & id_rsN!=0 & !stage_bubble & id_rsN==stage_dest`. No match is raised when `id_bubble`.
- Timeout counter is 8 bits:
  - Increments each cycle `mem_wait` is high and clears when it is low.
  - On reaching `MEM_TIMEOUT`, `bus_fault` pulses the next cycle and the counter clears.

## Timing
- Stall, squash and forward outputs are combinational from the current state and inputs, with zero latency.
- `trap_ack` and `bus_fault` are registered.
- Reset: state RUN, counter 0, `trap_ack`=0, `bus_fault`=0. While `rst_n` is low, all stall/squash outputs are 0 and `fwd_*`=FWD_NONE. Stage registers reset themselves.
- Redirect during `mem_wait`: the squash is suppressed. The branch is held in EX and the redirect takes effect the cycle `mem_wait` falls.
- Redirect together with a load-use hazard: the redirect wins and no stall is issued.
- `trap_req` during DRAIN/TRAP is ignored; the CSR unit holds it pending.
- Reset mid-DRAIN returns to RUN with no `trap_ack`.
- Minimum trap sequence is 3 cycles: RUN, DRAIN, TRAP, with MEM and WB already empty.

## Configuration
- Macro `HAZARD_FWD_EN`.
- **Defined**:
  - Forward from MEM (`FWD_MEM`) in preference to WB (`FWD_WB`).
  - Stall only on a load-use hazard, i.e. an ID source matching the EX destination while `ex_is_load`.
- **Undefined**:
  - `fwd_*` tied to FWD_NONE.
  - Stall on any source match against the EX, MEM or WB destination.

## Structure
- Add to the saratoga package:
  - `fwd_sel_t` (FWD_NONE=0, FWD_MEM=1, FWD_WB=2; 2 bits).
  - `hazard_state_t` (RUN, DRAIN, TRAP).
- Sub-module `raw_match` compares one source register against one stage destination. It is instantiated per source/stage pair.

## Test plan
- Load into x5 in EX; ID reads x5 as rs1 -> one cycle of `pc_stall`=1, `if_id_stall`=1, `id_ex_squash`=1; the next cycle is clean. With `HAZARD_FWD_EN`, the next cycle gives `fwd_rs1_sel`=FWD_MEM.
- ALU writes x7 in MEM; ID reads x7 as rs2 and x0 as rs1:
  - With `HAZARD_FWD_EN`: `fwd_rs2_sel`=FWD_MEM and no stall.
  - Without it: stall until WB has passed, 2 cycles.
- `ex_redirect` during 3 cycles of `mem_wait` -> no squash for 3 cycles, then `if_id_squash` and `id_ex_squash` in cycle 4.
- `trap_req` with MEM valid and `mem_wait` high for 2 cycles -> DRAIN lasts until MEM/WB are empty, then `trap_ack` for exactly 1 cycle, then RUN.
- `mem_wait` held for 300 cycles with `MEM_TIMEOUT`=255 -> exactly one `bus_fault` pulse at cycle 256.
- Assert `rst_n`=0 during DRAIN -> next cycle state is RUN, all outputs 0, no `trap_ack`.
